// File: rtl/inst_sram_fetch_ctrl.sv
// Instruction SRAM fetch controller: two 16-bit SRAM reads (high half first) per 32-bit fetch.
// Optional last-instruction hit path enabled by defining LAST_INST_HIT_EN.
module inst_sram_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 20,
    parameter int unsigned INST_WIDTH      = 32,
    parameter int unsigned SRAM_DATA_WIDTH = 16,
    parameter int unsigned WAIT_STATES     = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       req_in,
    input  logic [ADDR_WIDTH-1:0]      req_addr_in,
    input  logic                       flush_in,
    output logic [INST_WIDTH-1:0]      inst_out,
    output logic                       inst_valid_out,
    output logic                       clk_en_out,
    output logic                       misalign_err_out,
    output logic [ADDR_WIDTH-1:0]      sram_addr_out,
    output logic                       sram_cs_n_out,
    output logic                       sram_oe_n_out,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_data_in
);

    typedef enum logic [1:0] {StIdle, StRdHi, StRdLo, StDone} state_e;

    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

    state_e                r_state;
    logic [3:0]            r_wait;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_cs_n;
    logic                  r_oe_n;
    logic                  r_misalign;

    logic w_accepting;
    logic w_take;
    logic w_misalign;
    logic w_start;
    logic w_hit;

    assign w_accepting = (r_state == StIdle) || (r_state == StDone);
    // A flush alongside a request in an accepting state drops the request outright.
    assign w_take      = w_accepting && req_in && !flush_in;
    assign w_misalign  = w_take && req_addr_in[0];
    assign w_start     = w_take && !req_addr_in[0];

`ifdef LAST_INST_HIT_EN
    logic [ADDR_WIDTH-1:0] r_tag;
    logic                  r_tag_vld;
    logic [INST_WIDTH-1:0] r_hold;

    assign w_hit = w_start && r_tag_vld && (req_addr_in == r_tag);

    // Tag is only refreshed by an access that completes both reads.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tag     <= '0;
            r_tag_vld <= 1'b0;
            r_hold    <= '0;
        end else if (r_state == StRdLo && !flush_in && r_wait == 4'd0) begin
            r_tag     <= r_addr;
            r_tag_vld <= 1'b1;
            r_hold    <= {r_inst[INST_WIDTH-1 -: SRAM_DATA_WIDTH], sram_data_in};
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= StIdle;
            r_wait      <= 4'd0;
            r_addr      <= '0;
            r_sram_addr <= '0;
            r_inst      <= '0;
            r_cs_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    r_state <= StIdle;
                    if (w_misalign) begin
                        r_misalign <= 1'b1;
                    end else if (w_hit) begin
`ifdef LAST_INST_HIT_EN
                        r_inst  <= r_hold;
`endif
                        r_state <= StDone;
                    end else if (w_start) begin
                        r_state     <= StRdHi;
                        r_addr      <= req_addr_in;
                        r_sram_addr <= req_addr_in;
                        r_cs_n      <= 1'b0;
                        r_oe_n      <= 1'b0;
                        r_wait      <= WaitInit;
                    end
                end
                StRdHi: begin
                    if (flush_in) begin
                        r_state <= StIdle;
                        r_cs_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                    end else if (r_wait == 4'd0) begin
                        r_inst[INST_WIDTH-1 -: SRAM_DATA_WIDTH] <= sram_data_in;
                        r_state     <= StRdLo;
                        r_wait      <= WaitInit;
                        // Address is even, so setting bit 0 never carries.
                        r_sram_addr <= {r_addr[ADDR_WIDTH-1:1], 1'b1};
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                StRdLo: begin
                    if (flush_in) begin
                        r_state <= StIdle;
                        r_cs_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                    end else if (r_wait == 4'd0) begin
                        r_inst[SRAM_DATA_WIDTH-1:0] <= sram_data_in;
                        r_state <= StDone;
                        r_cs_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign inst_out         = r_inst;
    assign inst_valid_out   = (r_state == StDone) && !flush_in;
    assign clk_en_out       = w_accepting;
    assign misalign_err_out = r_misalign;
    assign sram_addr_out    = r_sram_addr;
    assign sram_cs_n_out    = r_cs_n;
    assign sram_oe_n_out    = r_oe_n;

endmodule

// File: tb/tb_inst_sram_fetch_ctrl.sv
// Bench for inst_sram_fetch_ctrl: three instances (WAIT_STATES 0,1,2) share one stimulus stream
// and are compared each cycle against a countdown-based reference model.
module tb_inst_sram_fetch_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_in;
    logic [19:0] req_addr_in;
    logic        flush_in;

    logic [31:0] inst_o   [3];
    logic        valid_o  [3];
    logic        clk_en_o [3];
    logic        mis_o    [3];
    logic [19:0] saddr_o  [3];
    logic        cs_n_o   [3];
    logic        oe_n_o   [3];
    logic [15:0] sdata    [3];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LAST_INST_HIT_EN
    localparam bit Hit = 1'b1;
`else
    localparam bit Hit = 1'b0;
`endif

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] sram_word(input logic [19:0] a);
        logic [31:0] t;
        if (a == 20'h00010) return 16'hABCD;
        if (a == 20'h00011) return 16'h1234;
        t = {12'h0, a} * 32'd40503;
        return t[15:0] ^ t[31:16] ^ 16'h5A5A;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign sdata[g] = sram_word(saddr_o[g]);
        inst_sram_fetch_ctrl #(
            .WAIT_STATES(g)
        ) u_dut (
            .clk_in          (clk_in),
            .rst_in          (rst_in),
            .req_in          (req_in),
            .req_addr_in     (req_addr_in),
            .flush_in        (flush_in),
            .inst_out        (inst_o[g]),
            .inst_valid_out  (valid_o[g]),
            .clk_en_out      (clk_en_o[g]),
            .misalign_err_out(mis_o[g]),
            .sram_addr_out   (saddr_o[g]),
            .sram_cs_n_out   (cs_n_o[g]),
            .sram_oe_n_out   (oe_n_o[g]),
            .sram_data_in    (sdata[g])
        );
    end

    // Reference model: an access is a block of 2W+2 busy cycles, first half on addr, second on addr|1.
    int          m_left  [3];
    bit          m_done  [3];
    bit          m_err   [3];
    logic [19:0] m_addr  [3];
    logic [19:0] m_saddr [3];
    logic [31:0] m_inst  [3];
    bit          m_tvld  [3];
    logic [19:0] m_tag   [3];
    logic [31:0] m_hold  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0; m_done[k] = 0; m_err[k] = 0;
            m_addr[k] = '0; m_saddr[k] = '0; m_inst[k] = '0;
            m_tvld[k] = 0; m_tag[k] = '0; m_hold[k] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int total;
            logic [19:0] a1;
            total    = 2 * k + 2;
            a1       = {m_addr[k][19:1], 1'b1};
            m_err[k] = 0;
            if (m_left[k] > 0) begin
                if (flush_in) begin
                    m_left[k] = 0;
                    m_done[k] = 0;
                end else begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_done[k] = 1;
                        m_inst[k] = {sram_word(m_addr[k]), sram_word(a1)};
                        m_tag[k]  = m_addr[k];
                        m_hold[k] = m_inst[k];
                        m_tvld[k] = 1;
                    end else if (total - m_left[k] >= k + 1) begin
                        m_saddr[k] = a1;
                    end
                end
            end else begin
                m_done[k] = 0;
                if (req_in && !flush_in) begin
                    if (req_addr_in[0]) begin
                        m_err[k] = 1;
                    end else if (Hit && m_tvld[k] && req_addr_in == m_tag[k]) begin
                        m_done[k] = 1;
                        m_inst[k] = m_hold[k];
                    end else begin
                        m_left[k]  = total;
                        m_addr[k]  = req_addr_in;
                        m_saddr[k] = req_addr_in;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s [W=%0d]: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            bit exp_valid;
            exp_valid = m_done[k] && !flush_in;
            chk("clk_en", k, 32'(clk_en_o[k]), 32'(m_left[k] == 0));
            chk("cs_n", k, 32'(cs_n_o[k]), 32'(m_left[k] == 0));
            chk("oe_n", k, 32'(oe_n_o[k]), 32'(m_left[k] == 0));
            chk("sram_addr", k, 32'(saddr_o[k]), 32'(m_saddr[k]));
            chk("valid", k, 32'(valid_o[k]), 32'(exp_valid));
            chk("misalign", k, 32'(mis_o[k]), 32'(m_err[k]));
            if (exp_valid) chk("inst", k, inst_o[k], m_inst[k]);
        end
    endtask

    task automatic reset_checks();
        for (int k = 0; k < 3; k++) begin
            chk("rst_inst", k, inst_o[k], 32'h0);
            chk("rst_valid", k, 32'(valid_o[k]), 32'h0);
            chk("rst_clk_en", k, 32'(clk_en_o[k]), 32'h1);
            chk("rst_misalign", k, 32'(mis_o[k]), 32'h0);
            chk("rst_sram_addr", k, 32'(saddr_o[k]), 32'h0);
            chk("rst_cs_n", k, 32'(cs_n_o[k]), 32'h1);
            chk("rst_oe_n", k, 32'(oe_n_o[k]), 32'h1);
        end
    endtask

    // Called at a falling edge: drive, check current outputs, then advance one clock.
    task automatic cycle(input logic req, input logic [19:0] a, input logic fl);
        req_in      = req;
        req_addr_in = a;
        flush_in    = fl;
        #1 check_all();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 20'h0, 1'b0);
    endtask

    initial begin
        int first;
        int second;
        int lows;
        rst_in      = 1'b1;
        req_in      = 1'b0;
        req_addr_in = '0;
        flush_in    = 1'b0;
        model_reset();
        @(negedge clk_in);
        #1 reset_checks();
        @(negedge clk_in);
        rst_in = 1'b0;
        idle(2);

        // Reset in the middle of RD_LO (W=1 instance)
        cycle(1'b1, 20'h00040, 1'b0);
        idle(2);
        chk("rdlo_cs_n", 1, 32'(cs_n_o[1]), 32'h0);
        chk("rdlo_addr", 1, 32'(saddr_o[1]), 32'h00041);
        rst_in = 1'b1;
        #1;
        model_reset();
        reset_checks();
        @(negedge clk_in);
        reset_checks();
        rst_in = 1'b0;
        idle(3);

        // W=0 fetch of 0x00010
        cycle(1'b1, 20'h00010, 1'b0);
        chk("w0_clk_en_c1", 0, 32'(clk_en_o[0]), 32'h0);
        cycle(1'b0, 20'h0, 1'b0);
        chk("w0_clk_en_c2", 0, 32'(clk_en_o[0]), 32'h0);
        chk("w0_valid_c2", 0, 32'(valid_o[0]), 32'h0);
        cycle(1'b0, 20'h0, 1'b0);
        chk("w0_clk_en_c3", 0, 32'(clk_en_o[0]), 32'h1);
        chk("w0_valid_c3", 0, 32'(valid_o[0]), 32'h1);
        chk("w0_inst", 0, inst_o[0], 32'hABCD1234);
        idle(8);

`ifdef LAST_INST_HIT_EN
        // Repeat of the last fetched address is served without touching the SRAM
        cycle(1'b1, 20'h00010, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("hit_valid", k, 32'(valid_o[k]), 32'h1);
            chk("hit_inst", k, inst_o[k], 32'hABCD1234);
            chk("hit_cs_n", k, 32'(cs_n_o[k]), 32'h1);
        end
        idle(2);
`endif

        // W=2 back-to-back 0x00000 then 0x00002
        first  = -1;
        second = -1;
        lows   = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(i <= 7, (i == 0) ? 20'h00000 : 20'h00002, 1'b0);
            if (cs_n_o[2] == 1'b0) lows++;
            if (valid_o[2] == 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        chk("b2b_gap", 2, 32'(second - first), 32'd7);
        chk("b2b_cs_low", 2, 32'(lows), 32'd12);
        idle(8);

        // Flush during the second RD_HI cycle of the W=1 instance
        cycle(1'b1, 20'h00020, 1'b0);
        cycle(1'b0, 20'h0, 1'b0);
        cycle(1'b0, 20'h0, 1'b1);
        chk("flush_clk_en", 1, 32'(clk_en_o[1]), 32'h1);
        chk("flush_cs_n", 1, 32'(cs_n_o[1]), 32'h1);
        chk("flush_valid", 1, 32'(valid_o[1]), 32'h0);
        idle(1);
        cycle(1'b1, 20'h00100, 1'b0);
        idle(4);
        chk("post_flush_valid", 1, 32'(valid_o[1]), 32'h1);
        chk("post_flush_inst", 1, inst_o[1], {sram_word(20'h00100), sram_word(20'h00101)});
        idle(8);

        // Misaligned request
        cycle(1'b1, 20'h00005, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("mis_pulse", k, 32'(mis_o[k]), 32'h1);
            chk("mis_cs_n", k, 32'(cs_n_o[k]), 32'h1);
            chk("mis_clk_en", k, 32'(clk_en_o[k]), 32'h1);
        end
        cycle(1'b0, 20'h0, 1'b0);
        for (int k = 0; k < 3; k++) chk("mis_clear", k, 32'(mis_o[k]), 32'h0);

        // Flush together with a request in an accepting state drops the request
        cycle(1'b1, 20'h00030, 1'b1);
        for (int k = 0; k < 3; k++) chk("flush_req_cs_n", k, 32'(cs_n_o[k]), 32'h1);
        idle(2);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            logic        r;
            logic        f;
            logic [19:0] a;
            int          sel;
            r   = ($urandom_range(0, 99) < 45);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       a = 20'h00010;
                1:       a = 20'h00100;
                2:       a = 20'hFFFFE;
                3:       a = 20'($urandom) | 20'h1;
                default: a = 20'($urandom) & 20'hFFFFE;
            endcase
            f = ($urandom_range(0, 9) == 0);
            if (f) a[0] = 1'b0;
            cycle(r, a, f);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
